// File: rtl/mem_arb2.sv
// Two-master round-robin arbiter for the native picorv32 memory bus, one grant per transaction.
// Optional slave watchdog (TIMEOUT cycles, ERR_RDATA response) is built when MEM_ARB2_TIMEOUT_EN is defined.
module mem_arb2 #(
    parameter int          TIMEOUT   = 1024,
    parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        err
);
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("mem_arb2: TIMEOUT must be >= 2");
    end

    // Encoding doubles as the one-hot grant, so grant is a plain register read.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t state_q;
    logic   last_q;
    logic   tmo;

`ifdef MEM_ARB2_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        err_q;

    // Real completion wins over the watchdog when both land in the same cycle.
    assign tmo = (state_q != IDLE) && !s_ready && (cnt_q == 16'(TIMEOUT - 1));
    assign err = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == IDLE)
                cnt_q <= '0;
            else if (!s_ready)
                cnt_q <= cnt_q + 16'd1;
            if (tmo)
                err_q <= 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (m0_valid && (!m1_valid || last_q))
                        state_q <= OWN0;
                    else if (m1_valid)
                        state_q <= OWN1;
                end
                OWN0: begin
                    if (s_ready || tmo) begin
                        state_q <= IDLE;
                        last_q  <= 1'b0;
                    end else if (!m0_valid) begin
                        state_q <= IDLE;
                    end
                end
                OWN1: begin
                    if (s_ready || tmo) begin
                        state_q <= IDLE;
                        last_q  <= 1'b1;
                    end else if (!m1_valid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant = state_q;

    always_comb begin
        s_valid  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        unique case (state_q)
            OWN0: begin
                s_valid  = m0_valid && !tmo;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_wstrb  = m0_wstrb;
                m0_ready = s_ready || tmo;
            end
            OWN1: begin
                s_valid  = m1_valid && !tmo;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wstrb  = m1_wstrb;
                m1_ready = s_ready || tmo;
            end
            default: ;
        endcase
    end

    assign m0_rdata = (tmo && state_q == OWN0) ? ERR_RDATA : s_rdata;
    assign m1_rdata = (tmo && state_q == OWN1) ? ERR_RDATA : s_rdata;
endmodule

// File: tb/tb_mem_arb2.sv
// Scoreboard bench for mem_arb2: directed master transactions, a latency-programmable slave model,
// and a negedge monitor that pops expected slave transactions and master responses.
module tb_mem_arb2;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mv = '0;
    logic [1:0]  mrdy;
    logic [31:0] maddr [2];
    logic [31:0] mwd   [2];
    logic [3:0]  mws   [2];
    logic [31:0] mrd   [2];
    logic        s_valid, s_ready;
    logic        slv_rdy = 1'b0;
    logic        stray = 1'b0;
    logic [31:0] s_addr, s_wdata;
    logic [31:0] s_rdata = '0;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;
    logic        err;
    int          slv_lat = 1;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;
    assign s_ready = slv_rdy | stray;

    mem_arb2 #(.TIMEOUT(8), .ERR_RDATA(32'hDEADBEEF)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(mv[0]), .m0_ready(mrdy[0]), .m0_addr(maddr[0]), .m0_wdata(mwd[0]),
        .m0_wstrb(mws[0]), .m0_rdata(mrd[0]),
        .m1_valid(mv[1]), .m1_ready(mrdy[1]), .m1_addr(maddr[1]), .m1_wdata(mwd[1]),
        .m1_wstrb(mws[1]), .m1_rdata(mrd[1]),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .grant(grant), .err(err)
    );

    typedef struct { logic [1:0] g; logic [31:0] a; logic [31:0] wd; logic [3:0] ws; } sxact_t;
    typedef struct { logic cmp; logic [31:0] rd; } mresp_t;
    sxact_t exp_s[$];
    mresp_t exp_m0[$];
    mresp_t exp_m1[$];
    sxact_t se;
    mresp_t re;

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return (a == 32'h5000_0004) ? 32'h1234_5678 : (a ^ 32'hFFFF_0000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", name);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_rd(input int m, input logic [31:0] a, input logic [31:0] rd);
        exp_s.push_back('{g: (m == 0) ? 2'b01 : 2'b10, a: a, wd: 32'h0, ws: 4'h0});
        if (m == 0) exp_m0.push_back('{cmp: 1'b1, rd: rd});
        else        exp_m1.push_back('{cmp: 1'b1, rd: rd});
    endtask

    task automatic exp_wr(input int m, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        exp_s.push_back('{g: (m == 0) ? 2'b01 : 2'b10, a: a, wd: wd, ws: ws});
        if (m == 0) exp_m0.push_back('{cmp: 1'b0, rd: 32'h0});
        else        exp_m1.push_back('{cmp: 1'b0, rd: 32'h0});
    endtask

    // Waits for the master's ready pulse, then drops its request after the completing edge.
    task automatic wait_ready(input int m, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mrdy[m] && n < budget);
        if (!mrdy[m]) bad($sformatf("ready_timeout m%0d: no ready within %0d cycles", m, budget));
        sync();
        mv[m] = 1'b0;
    endtask

    task automatic xfer(input int m, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        mv[m] = 1'b1; maddr[m] = a; mwd[m] = wd; mws[m] = ws;
        wait_ready(m, 50);
    endtask

    task automatic wait_grant(input logic [1:0] g, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant !== g && n < budget);
        if (grant !== g) bad($sformatf("grant_timeout: actual %0b required %0b", grant, g));
    endtask

    // Slave model: ready on the slv_lat-th consecutive s_valid cycle; slv_lat = 0 never answers.
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (s_valid && slv_lat > 0) begin
                cnt++;
                slv_rdy = (cnt == slv_lat);
                s_rdata = slv_rdy ? rd_val(s_addr) : 32'h0;
            end else begin
                cnt = 0;
                slv_rdy = 1'b0;
                s_rdata = 32'h0;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (s_valid && s_ready) begin
                if (exp_s.size() == 0) begin
                    bad($sformatf("s_xact: unexpected transfer addr %0h", s_addr));
                end else begin
                    se = exp_s.pop_front();
                    chk("s_owner", 32'(grant), 32'(se.g));
                    chk("s_addr", s_addr, se.a);
                    chk("s_wdata", s_wdata, se.wd);
                    chk("s_wstrb", 32'(s_wstrb), 32'(se.ws));
                end
            end
            if (mrdy[0]) begin
                chk("m0_ready_owner", 32'(grant), 32'(2'b01));
                if (exp_m0.size() == 0) bad("m0_ready: unexpected pulse, actual 1 required 0");
                else begin
                    re = exp_m0.pop_front();
                    if (re.cmp) chk("m0_rdata", mrd[0], re.rd);
                end
            end
            if (mrdy[1]) begin
                chk("m1_ready_owner", 32'(grant), 32'(2'b10));
                if (exp_m1.size() == 0) bad("m1_ready: unexpected pulse, actual 1 required 0");
                else begin
                    re = exp_m1.pop_front();
                    if (re.cmp) chk("m1_rdata", mrd[1], re.rd);
                end
            end
            if (grant == 2'b01) begin
                chk("route0_addr", s_addr, maddr[0]);
                chk("route0_wdata", s_wdata, mwd[0]);
            end else if (grant == 2'b10) begin
                chk("route1_addr", s_addr, maddr[1]);
                chk("route1_wdata", s_wdata, mwd[1]);
            end else begin
                chk("idle_svalid", 32'(s_valid), 32'h0);
                chk("idle_saddr", s_addr, 32'h0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] gs[5];
        logic [1:0] gexp[5] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        int n;
        for (int i = 0; i < 2; i++) begin
            maddr[i] = '0; mwd[i] = '0; mws[i] = '0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_svalid", 32'(s_valid), 32'h0);
        chk("rst_ready", 32'(mrdy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Single m0 read, slave answers on its 3rd cycle
        slv_lat = 3;
        exp_rd(0, 32'h5000_0004, 32'h1234_5678);
        sync();
        mv[0] = 1'b1; maddr[0] = 32'h5000_0004; mwd[0] = '0; mws[0] = '0;
        @(negedge clk);
        chk("t1_arb_grant", 32'(grant), 32'h0);
        chk("t1_arb_svalid", 32'(s_valid), 32'h0);
        @(negedge clk);
        chk("t1_own_grant", 32'(grant), 32'(2'b01));
        chk("t1_own_svalid", 32'(s_valid), 32'h1);
        wait_ready(0, 20);
        @(negedge clk);
        chk("t1_after_grant", 32'(grant), 32'h0);

        // Simultaneous first request after reset: m0, one IDLE cycle, then m1
        sync(); rst = 1'b1;
        sync(); rst = 1'b0;
        slv_lat = 1;
        exp_rd(0, 32'h0000_0010, 32'hFFFF_0010);
        exp_rd(1, 32'h0000_0020, 32'hFFFF_0020);
        sync();
        fork
            xfer(0, 32'h0000_0010, 32'h0, 4'h0);
            xfer(1, 32'h0000_0020, 32'h0, 4'h0);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    gs[i] = grant;
                end
            end
        join
        for (int i = 0; i < 5; i++) chk($sformatf("t2_grant_seq%0d", i), 32'(gs[i]), 32'(gexp[i]));

        // Continuous contention: 4 writes each, strict alternation starting with m0
        slv_lat = 1;
        for (int i = 0; i < 4; i++) begin
            exp_wr(0, 32'h0000_1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
            exp_wr(1, 32'h0000_2000 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'h3);
        end
        sync();
        fork
            begin
                for (int i = 0; i < 4; i++) xfer(0, 32'h0000_1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
            end
            begin
                for (int j = 0; j < 4; j++) xfer(1, 32'h0000_2000 + 32'(4 * j), 32'hB000_0000 + 32'(j), 4'h3);
            end
        join

        // Reset while m1 owns the slave; the held request is re-granted afterwards
        slv_lat = 3;
        exp_rd(1, 32'h0000_4000, 32'hFFFF_4000);
        sync();
        mv[1] = 1'b1; maddr[1] = 32'h0000_4000; mwd[1] = '0; mws[1] = '0;
        wait_grant(2'b10, 10);
        sync(); rst = 1'b1;
        sync(); rst = 1'b0;
        #2;
        chk("t4_abort_grant", 32'(grant), 32'h0);
        chk("t4_abort_svalid", 32'(s_valid), 32'h0);
        chk("t4_abort_ready", 32'(mrdy[1]), 32'h0);
        wait_ready(1, 20);

        // m0 completes once so last = m0, then m0 drops valid mid-grant and re-raises
        slv_lat = 1;
        exp_rd(0, 32'h0000_5000, 32'hFFFF_5000);
        xfer(0, 32'h0000_5000, 32'h0, 4'h0);
        slv_lat = 4;
        exp_rd(1, 32'h0000_6000, 32'hFFFF_6000);
        exp_rd(0, 32'h0000_7000, 32'hFFFF_7000);
        sync();
        mv[0] = 1'b1; maddr[0] = 32'h0000_7000;
        wait_grant(2'b01, 10);
        sync();
        mv[0] = 1'b0;
        mv[1] = 1'b1; maddr[1] = 32'h0000_6000;
        sync();
        mv[0] = 1'b1;
        #2;
        chk("t5_abort_grant", 32'(grant), 32'h0);
        chk("t5_abort_ready", 32'(mrdy), 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("t5_m1_wins", 32'(grant), 32'(2'b10));
        fork
            wait_ready(1, 30);
            wait_ready(0, 40);
        join

        // Stray s_ready while idle is ignored
        sync();
        stray = 1'b1;
        @(negedge clk);
        chk("t6_stray_ready", 32'(mrdy), 32'h0);
        chk("t6_stray_grant", 32'(grant), 32'h0);
        sync();
        stray = 1'b0;

`ifdef MEM_ARB2_TIMEOUT_EN
        // Silent slave: error response in the 8th owned cycle, sticky err, then a normal access
        slv_lat = 0;
        exp_m0.push_back('{cmp: 1'b1, rd: 32'hDEAD_BEEF});
        sync();
        mv[0] = 1'b1; maddr[0] = 32'h0000_8000; mwd[0] = '0; mws[0] = '0;
        wait_grant(2'b01, 10);
        n = 1;
        while (!mrdy[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t7_tmo_cycle", 32'(n), 32'd8);
        chk("t7_tmo_svalid", 32'(s_valid), 32'h0);
        sync();
        mv[0] = 1'b0;
        chk("t7_err_set", 32'(err), 32'h1);
        slv_lat = 2;
        exp_rd(0, 32'h5000_0004, 32'h1234_5678);
        xfer(0, 32'h5000_0004, 32'h0, 4'h0);
        chk("t7_err_sticky", 32'(err), 32'h1);
`else
        chk("err_tied_low", 32'(err), 32'h0);
`endif

        repeat (3) @(negedge clk);
        chk("left_s_xacts", 32'(exp_s.size()), 32'h0);
        chk("left_m0_resps", 32'(exp_m0.size()), 32'h0);
        chk("left_m1_resps", 32'(exp_m1.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
